ram_writeback_bridge: RTL and testbench
=======================================

# ram_writeback_bridge

Write-side counterpart of the FFT operand read pipeline: takes butterfly results (X = sum, Y = difference) with the address and operand-mux control of the beat that produced them, and drives the two single-port-write RAM banks (A, B). It undoes the even/odd operand pairing so that each bank takes at most one write per cycle. It sits between the butterfly output stage and the RAM write ports, and reports stage completion and protocol errors to the FFT sequencer.

## Interface
- FFT_N, 10, log2 of FFT length; each bank holds 2^(FFT_N-1) words
- FFT_DW, 16, real/imag component width; a complex word is FFT_DW*2 bits
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high, on clk
- iact  in  1  result beat valid
- ictrl  in  2  beat mode: 10 = first stage, 00 = later stage even cycle, 11 = later stage odd cycle, 01 = illegal
- ilast  in  1  beat is the final beat of the current stage; qualified by iact
- input_memory_address  in  FFT_N-1  bank address of the beat
- input_X, input_Y  in  FFT_DW*2 each  butterfly results
- wr_en_A, wr_en_B  out  1 each  bank write strobes
- wr_addr_A, wr_addr_B  out  FFT_N-1 each  write addresses
- wr_data_A, wr_data_B  out  FFT_DW*2 each  write data
- stage_done  out  1  one-cycle pulse coincident with the last write of a stage
- busy  out  1  high while a held even result or a flush write is outstanding
- err_seq  out  1  sticky protocol error flag; cleared only by reset

## Operation
- All outputs are registered. On reset, every output is 0, the held-even slot is empty, and the flush slot is empty.
- First stage (10) beat at address a: next cycle write A[a]=X and B[a]=Y.
- Even beat (00) at address ae: next cycle write A[ae]=Xe. Capture Ye and ae in the held slot. The slot may wait any number of idle cycles.
- Odd beat (11) at address ao with the held slot full:
  - Next cycle: write A[ao]=Ye(held) and B[ae]=Xo.
  - Load the flush slot with Yo and ao.
  - The held slot becomes empty.
- Flush slot: write B[ao]=Yo in the cycle after the odd pair writes, then the slot becomes empty.
- For a steady e,o,e,o stream, the A write of the next even beat coincides with the flush B write.
- stage_done:
  - For an ilast beat in mode 10, it asserts with that beat's writes.
  - For an ilast beat in mode 11, it asserts with the flush write.
  - An ilast beat in mode 00 sets err_seq and produces no stage_done.
- Protocol errors set err_seq. In each case:
  - Odd beat with the held slot empty: the beat is dropped with no writes.
  - Even beat with the held slot full: the old held result is discarded and the new beat is processed normally.
  - ctrl=01: the beat is ignored.
  - Mode-10 beat while the held slot is full: the held result is discarded and the beat is processed.
  - Mode-10 beat whose write cycle collides with a flush write: the flush B write wins, the beat's A write proceeds, and the beat's B write is dropped.
- iact=0: ictrl, ilast, address and data are ignored. The flush write still occurs.
- busy = held slot full OR flush slot full, registered. It is low on the cycle stage_done is asserted for a mode-11 stage.
- Reset asserted mid-operation discards the held and flush slots. No write strobe is asserted in the cycle after reset is sampled high.

## Timing
- Latency from an iact beat to its first write is 1 cycle.
- Odd-pair B[ao] write latency is 2 cycles.
- Throughput is 1 beat/cycle in every legal sequence.
- wr_addr_* and wr_data_* are don't-care when the matching wr_en_* is 0. The implementation holds them at their last values.
- stage_done is never asserted on two consecutive cycles for a legal stream unless two ilast beats are back to back.

## Test plan
- Reset then first stage: after reset, beat 10 at a=5, X=0x00010002, Y=0x00030004, ilast=1.
  - Next cycle: A[5]=0x00010002, B[5]=0x00030004, stage_done=1.
  - All outputs 0 during reset.
- Even/odd pair:
  - Stimulus: even a=2, X=0xA, Y=0xB; then odd a=3, X=0xC, Y=0xD, ilast=1.
  - t+1: A[2]=0xA, busy=1.
  - t+2: A[3]=0xB and B[2]=0xC.
  - t+3: B[3]=0xD with stage_done=1 and busy=0.
- Streaming: eight back-to-back e,o beats with addresses 0..7.
  - Exactly one wr_en_A and at most one wr_en_B per cycle.
  - 16 total writes matching the pairing rules; err_seq=0.
- Gapped pair: even at a=4, then 3 idle cycles, then odd at a=9.
  - Held Y is written to A[9] and odd X to B[4]; busy=1 throughout the gap.
- Errors:
  - Odd with empty held slot: err_seq=1, no writes.
  - Two consecutive evens: the first held Y is never written.
  - ctrl=01: ignored.
  - err_seq stays 1 until reset.
- Reset mid-pair: reset asserted the cycle after an even beat.
  - No wr_en afterwards; busy=0; a following odd beat sets err_seq.

Source files
------------

// File: rtl/ram_writeback_bridge.sv
// ram_writeback_bridge
// Write-side counterpart of the FFT operand read pipeline. It accepts butterfly
// results (X = sum, Y = difference) tagged with the bank address and operand-mux
// mode of the producing beat. It re-pairs them into writes on the two RAM banks
// (A, B) so that each bank takes at most one write per cycle.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   iact                    result beat valid
//   ictrl[1:0]              10 first stage, 00 later-stage even, 11 later-stage odd, 01 illegal
//   ilast                   final beat of the stage (qualified by iact)
//   input_memory_address    bank address of the beat
//   input_X, input_Y        butterfly results
//   wr_en_A/B, wr_addr_A/B, wr_data_A/B   registered bank write ports
//   stage_done              pulse with the last write of a stage
//   busy                    held-even or flush write outstanding
//   err_seq                 sticky protocol error flag, cleared only by reset
module ram_writeback_bridge #(
    parameter int FFT_N  = 10,
    parameter int FFT_DW = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  iact,
    input  logic [1:0]            ictrl,
    input  logic                  ilast,
    input  logic [FFT_N-2:0]      input_memory_address,
    input  logic [FFT_DW*2-1:0]   input_X,
    input  logic [FFT_DW*2-1:0]   input_Y,
    output logic                  wr_en_A,
    output logic                  wr_en_B,
    output logic [FFT_N-2:0]      wr_addr_A,
    output logic [FFT_N-2:0]      wr_addr_B,
    output logic [FFT_DW*2-1:0]   wr_data_A,
    output logic [FFT_DW*2-1:0]   wr_data_B,
    output logic                  stage_done,
    output logic                  busy,
    output logic                  err_seq
);
    localparam int AW = FFT_N - 1;
    localparam int DW = FFT_DW * 2;

    // Held even result: Y and address of the even beat, waiting for its odd partner.
    logic          r_held_valid;
    logic [DW-1:0] r_held_y;
    logic [AW-1:0] r_held_addr;
    // Flush slot: odd-beat Y and address, written to bank B one cycle after the pair.
    logic          r_flush_valid;
    logic [DW-1:0] r_flush_y;
    logic [AW-1:0] r_flush_addr;
    logic          r_flush_last;

    logic          w_en_a_next, w_en_b_next;
    logic [AW-1:0] w_addr_a_next, w_addr_b_next;
    logic [DW-1:0] w_data_a_next, w_data_b_next;
    logic          w_done_next, w_err_next, w_busy_next;
    logic          w_held_valid_next;
    logic [DW-1:0] w_held_y_next;
    logic [AW-1:0] w_held_addr_next;
    logic          w_flush_valid_next;
    logic [DW-1:0] w_flush_y_next;
    logic [AW-1:0] w_flush_addr_next;
    logic          w_flush_last_next;

    always_comb begin
        w_en_a_next        = 1'b0;
        w_en_b_next        = 1'b0;
        w_addr_a_next      = wr_addr_A;
        w_addr_b_next      = wr_addr_B;
        w_data_a_next      = wr_data_A;
        w_data_b_next      = wr_data_B;
        w_done_next        = 1'b0;
        w_err_next         = err_seq;
        w_held_valid_next  = r_held_valid;
        w_held_y_next      = r_held_y;
        w_held_addr_next   = r_held_addr;
        // A pending flush always drains this cycle.
        w_flush_valid_next = 1'b0;
        w_flush_y_next     = r_flush_y;
        w_flush_addr_next  = r_flush_addr;
        w_flush_last_next  = r_flush_last;

        if (r_flush_valid) begin
            w_en_b_next   = 1'b1;
            w_addr_b_next = r_flush_addr;
            w_data_b_next = r_flush_y;
            w_done_next   = r_flush_last;
        end

        if (iact) begin
            unique case (ictrl)
                2'b10: begin
                    w_en_a_next   = 1'b1;
                    w_addr_a_next = input_memory_address;
                    w_data_a_next = input_X;
                    if (r_held_valid) begin
                        w_err_next        = 1'b1;
                        w_held_valid_next = 1'b0;
                    end
                    // The flush owns bank B this cycle; the beat's B write is lost.
                    if (r_flush_valid) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_en_b_next   = 1'b1;
                        w_addr_b_next = input_memory_address;
                        w_data_b_next = input_Y;
                    end
                    if (ilast) w_done_next = 1'b1;
                end
                2'b00: begin
                    w_en_a_next       = 1'b1;
                    w_addr_a_next     = input_memory_address;
                    w_data_a_next     = input_X;
                    if (r_held_valid || ilast) w_err_next = 1'b1;
                    w_held_valid_next = 1'b1;
                    w_held_y_next     = input_Y;
                    w_held_addr_next  = input_memory_address;
                end
                2'b11: begin
                    if (r_held_valid) begin
                        // Cross-write: held even Y to A[ao], odd X to B[ae].
                        w_en_a_next        = 1'b1;
                        w_addr_a_next      = input_memory_address;
                        w_data_a_next      = r_held_y;
                        w_en_b_next        = 1'b1;
                        w_addr_b_next      = r_held_addr;
                        w_data_b_next      = input_X;
                        w_held_valid_next  = 1'b0;
                        w_flush_valid_next = 1'b1;
                        w_flush_y_next     = input_Y;
                        w_flush_addr_next  = input_memory_address;
                        w_flush_last_next  = ilast;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
                default: w_err_next = 1'b1;
            endcase
        end

        w_busy_next = w_held_valid_next || w_flush_valid_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_A       <= 1'b0;
            wr_en_B       <= 1'b0;
            wr_addr_A     <= '0;
            wr_addr_B     <= '0;
            wr_data_A     <= '0;
            wr_data_B     <= '0;
            stage_done    <= 1'b0;
            busy          <= 1'b0;
            err_seq       <= 1'b0;
            r_held_valid  <= 1'b0;
            r_held_y      <= '0;
            r_held_addr   <= '0;
            r_flush_valid <= 1'b0;
            r_flush_y     <= '0;
            r_flush_addr  <= '0;
            r_flush_last  <= 1'b0;
        end else begin
            wr_en_A       <= w_en_a_next;
            wr_en_B       <= w_en_b_next;
            wr_addr_A     <= w_addr_a_next;
            wr_addr_B     <= w_addr_b_next;
            wr_data_A     <= w_data_a_next;
            wr_data_B     <= w_data_b_next;
            stage_done    <= w_done_next;
            busy          <= w_busy_next;
            err_seq       <= w_err_next;
            r_held_valid  <= w_held_valid_next;
            r_held_y      <= w_held_y_next;
            r_held_addr   <= w_held_addr_next;
            r_flush_valid <= w_flush_valid_next;
            r_flush_y     <= w_flush_y_next;
            r_flush_addr  <= w_flush_addr_next;
            r_flush_last  <= w_flush_last_next;
        end
    end
endmodule

// File: tb/tb_ram_writeback_bridge.sv
// Table-driven bench for ram_writeback_bridge. Each record holds one cycle of
// stimulus and the outputs required in the following cycle. Expected records
// are queued when the stimulus is driven and popped after the next clock edge.
module tb_ram_writeback_bridge;
    localparam int FFT_N  = 10;
    localparam int FFT_DW = 16;
    localparam int AW     = FFT_N - 1;
    localparam int DW     = FFT_DW * 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          iact;
    logic [1:0]    ictrl;
    logic          ilast;
    logic [AW-1:0] input_memory_address;
    logic [DW-1:0] input_X, input_Y;
    logic          wr_en_A, wr_en_B;
    logic [AW-1:0] wr_addr_A, wr_addr_B;
    logic [DW-1:0] wr_data_A, wr_data_B;
    logic          stage_done, busy, err_seq;

    always #5 clk = ~clk;

    ram_writeback_bridge #(.FFT_N(FFT_N), .FFT_DW(FFT_DW)) dut (
        .clk(clk), .reset(reset), .iact(iact), .ictrl(ictrl), .ilast(ilast),
        .input_memory_address(input_memory_address), .input_X(input_X), .input_Y(input_Y),
        .wr_en_A(wr_en_A), .wr_en_B(wr_en_B), .wr_addr_A(wr_addr_A), .wr_addr_B(wr_addr_B),
        .wr_data_A(wr_data_A), .wr_data_B(wr_data_B),
        .stage_done(stage_done), .busy(busy), .err_seq(err_seq)
    );

    typedef struct {
        logic          rst, act;
        logic [1:0]    ctrl;
        logic          last;
        logic [AW-1:0] addr;
        logic [DW-1:0] x, y;
        logic          ea;
        logic [AW-1:0] aa;
        logic [DW-1:0] da;
        logic          eb;
        logic [AW-1:0] ab;
        logic [DW-1:0] db;
        logic          done, bsy, err;
    } vec_t;

    vec_t vecs[64];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic vec_t v(input logic rst, input logic act, input logic [1:0] ctrl,
                               input logic last, input int addr, input int x, input int y,
                               input logic ea, input int aa, input int da,
                               input logic eb, input int ab, input int db,
                               input logic done, input logic bsy, input logic err);
        vec_t r;
        r.rst = rst; r.act = act; r.ctrl = ctrl; r.last = last;
        r.addr = AW'(addr); r.x = DW'(x); r.y = DW'(y);
        r.ea = ea; r.aa = AW'(aa); r.da = DW'(da);
        r.eb = eb; r.ab = AW'(ab); r.db = DW'(db);
        r.done = done; r.bsy = bsy; r.err = err;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s vec%0d: got %h, expected %h", name, idx, got, want);
        end
    endtask

    task automatic add(input vec_t r);
        vecs[n_vec] = r;
        n_vec++;
    endtask

    initial begin
        reset = 1'b1; iact = 1'b0; ictrl = 2'b00; ilast = 1'b0;
        input_memory_address = '0; input_X = '0; input_Y = '0;

        //    rst act ctrl  last addr x       y          eA aA da          eB aB db          done busy err
        // reset, then single first-stage beat
        add(v(1, 0, 2'b00, 0, 0, 0,          0,          0, 0, 0,          0, 0, 0,          0, 0, 0));
        add(v(1, 1, 2'b10, 1, 3, 32'h55,     32'h66,     0, 0, 0,          0, 0, 0,          0, 0, 0));
        add(v(0, 1, 2'b10, 1, 5, 32'h00010002, 32'h00030004, 1, 5, 32'h00010002, 1, 5, 32'h00030004, 1, 0, 0));
        add(v(0, 0, 2'b00, 0, 0, 0,          0,          0, 0, 0,          0, 0, 0,          0, 0, 0));
        // even/odd pair
        add(v(0, 1, 2'b00, 0, 2, 32'hA,      32'hB,      1, 2, 32'hA,      0, 0, 0,          0, 1, 0));
        add(v(0, 1, 2'b11, 1, 3, 32'hC,      32'hD,      1, 3, 32'hB,      1, 2, 32'hC,      0, 1, 0));
        add(v(0, 0, 2'b00, 0, 0, 0,          0,          0, 0, 0,          1, 3, 32'hD,      1, 0, 0));
        // streaming e0,o1,...,e6,o7: X = 0x100+a, Y = 0x200+a
        add(v(0, 1, 2'b00, 0, 0, 32'h100,    32'h200,    1, 0, 32'h100,    0, 0, 0,          0, 1, 0));
        add(v(0, 1, 2'b11, 0, 1, 32'h101,    32'h201,    1, 1, 32'h200,    1, 0, 32'h101,    0, 1, 0));
        add(v(0, 1, 2'b00, 0, 2, 32'h102,    32'h202,    1, 2, 32'h102,    1, 1, 32'h201,    0, 1, 0));
        add(v(0, 1, 2'b11, 0, 3, 32'h103,    32'h203,    1, 3, 32'h202,    1, 2, 32'h103,    0, 1, 0));
        add(v(0, 1, 2'b00, 0, 4, 32'h104,    32'h204,    1, 4, 32'h104,    1, 3, 32'h203,    0, 1, 0));
        add(v(0, 1, 2'b11, 0, 5, 32'h105,    32'h205,    1, 5, 32'h204,    1, 4, 32'h105,    0, 1, 0));
        add(v(0, 1, 2'b00, 0, 6, 32'h106,    32'h206,    1, 6, 32'h106,    1, 5, 32'h205,    0, 1, 0));
        add(v(0, 1, 2'b11, 1, 7, 32'h107,    32'h207,    1, 7, 32'h206,    1, 6, 32'h107,    0, 1, 0));
        add(v(0, 0, 2'b00, 0, 0, 0,          0,          0, 0, 0,          1, 7, 32'h207,    1, 0, 0));
        // gapped pair: even a=4, three idle cycles (ignored junk on the bus), odd a=9
        add(v(0, 1, 2'b00, 0, 4, 32'h44,     32'h55,     1, 4, 32'h44,     0, 0, 0,          0, 1, 0));
        add(v(0, 0, 2'b11, 1, 8, 32'hDEAD,   32'hBEEF,   0, 0, 0,          0, 0, 0,          0, 1, 0));
        add(v(0, 0, 2'b01, 0, 7, 32'h1,      32'h2,      0, 0, 0,          0, 0, 0,          0, 1, 0));
        add(v(0, 0, 2'b00, 0, 0, 0,          0,          0, 0, 0,          0, 0, 0,          0, 1, 0));
        add(v(0, 1, 2'b11, 0, 9, 32'h66,     32'h77,     1, 9, 32'h55,     1, 4, 32'h66,     0, 1, 0));
        add(v(0, 0, 2'b00, 0, 0, 0,          0,          0, 0, 0,          1, 9, 32'h77,     0, 0, 0));
        // odd with empty held slot: dropped, error
        add(v(0, 1, 2'b11, 0, 1, 32'h99,     32'h98,     0, 0, 0,          0, 0, 0,          0, 0, 1));
        add(v(0, 0, 2'b00, 0, 0, 0,          0,          0, 0, 0,          0, 0, 0,          0, 0, 1));
        // two evens: first held Y (0x12) is never written
        add(v(0, 1, 2'b00, 0, 1, 32'h11,     32'h12,     1, 1, 32'h11,     0, 0, 0,          0, 1, 1));
        add(v(0, 1, 2'b00, 0, 2, 32'h21,     32'h22,     1, 2, 32'h21,     0, 0, 0,          0, 1, 1));
        add(v(0, 1, 2'b11, 0, 3, 32'h31,     32'h32,     1, 3, 32'h22,     1, 2, 32'h31,     0, 1, 1));
        add(v(0, 0, 2'b00, 0, 0, 0,          0,          0, 0, 0,          1, 3, 32'h32,     0, 0, 1));
        // illegal ctrl 01: ignored, error stays
        add(v(0, 1, 2'b01, 1, 7, 32'h71,     32'h72,     0, 0, 0,          0, 0, 0,          0, 0, 1));
        // reset clears err; reset mid-pair discards the held slot
        add(v(1, 0, 2'b00, 0, 0, 0,          0,          0, 0, 0,          0, 0, 0,          0, 0, 0));
        add(v(0, 1, 2'b00, 0, 1, 32'h1,      32'h2,      1, 1, 32'h1,      0, 0, 0,          0, 1, 0));
        add(v(1, 0, 2'b00, 0, 0, 0,          0,          0, 0, 0,          0, 0, 0,          0, 0, 0));
        add(v(0, 1, 2'b11, 0, 3, 32'h5,      32'h6,      0, 0, 0,          0, 0, 0,          0, 0, 1));
        add(v(1, 0, 2'b00, 0, 0, 0,          0,          0, 0, 0,          0, 0, 0,          0, 0, 0));
        // mode-10 beat colliding with a flush write: flush wins bank B
        add(v(0, 1, 2'b00, 0, 1, 32'h1,      32'h2,      1, 1, 32'h1,      0, 0, 0,          0, 1, 0));
        add(v(0, 1, 2'b11, 0, 2, 32'h3,      32'h4,      1, 2, 32'h2,      1, 1, 32'h3,      0, 1, 0));
        add(v(0, 1, 2'b10, 1, 6, 32'h7,      32'h8,      1, 6, 32'h7,      1, 2, 32'h4,      1, 0, 1));
        add(v(0, 0, 2'b00, 0, 0, 0,          0,          0, 0, 0,          0, 0, 0,          0, 0, 1));
        // mode-10 beat while held slot full: held discarded, beat written
        add(v(1, 0, 2'b00, 0, 0, 0,          0,          0, 0, 0,          0, 0, 0,          0, 0, 0));
        add(v(0, 1, 2'b00, 0, 4, 32'hE1,     32'hE2,     1, 4, 32'hE1,     0, 0, 0,          0, 1, 0));
        add(v(0, 1, 2'b10, 0, 8, 32'hF1,     32'hF2,     1, 8, 32'hF1,     1, 8, 32'hF2,     0, 0, 1));
        add(v(0, 1, 2'b11, 0, 5, 32'hF3,     32'hF4,     0, 0, 0,          0, 0, 0,          0, 0, 1));

        @(negedge clk);
        for (int i = 0; i < n_vec; i++) begin
            vec_t e;
            reset = vecs[i].rst; iact = vecs[i].act; ictrl = vecs[i].ctrl; ilast = vecs[i].last;
            input_memory_address = vecs[i].addr; input_X = vecs[i].x; input_Y = vecs[i].y;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk("wr_en_A", i, 32'(wr_en_A), 32'(e.ea));
            chk("wr_en_B", i, 32'(wr_en_B), 32'(e.eb));
            if (e.ea) begin
                chk("wr_addr_A", i, 32'(wr_addr_A), 32'(e.aa));
                chk("wr_data_A", i, wr_data_A, e.da);
            end
            if (e.eb) begin
                chk("wr_addr_B", i, 32'(wr_addr_B), 32'(e.ab));
                chk("wr_data_B", i, wr_data_B, e.db);
            end
            chk("stage_done", i, 32'(stage_done), 32'(e.done));
            chk("busy", i, 32'(busy), 32'(e.bsy));
            chk("err_seq", i, 32'(err_seq), 32'(e.err));
            $display("vec%0d rst=%0b act=%0b ctrl=%b a=%0d | A:%0b[%0d]=%h B:%0b[%0d]=%h done=%0b busy=%0b err=%0b",
                     i, e.rst, e.act, e.ctrl, e.addr, wr_en_A, wr_addr_A, wr_data_A,
                     wr_en_B, wr_addr_B, wr_data_B, stage_done, busy, err_seq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
